program_loader: RTL and testbench
=================================

# program_loader

Upstream feeder for the 4-bit CPU top level. It accepts a framed byte stream over a valid/ready handshake and assembles 18-bit instruction words. It writes them into the CPU's 9-entry program RAM through the RAM_WA/RAM_WD/RAM_EN load port. After a verified frame it raises PC_EN to release the CPU; RAM_EN and PC_EN are never active together.

## Interface

- WORDS, 9, number of program RAM entries (max frame word count)
- ADDR_W, 4, RAM address width
- DATA_W, 18, instruction word width
- clk  in  1  system clock; same clk as the CPU's RAM and PC
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_byte holds a byte
- in_byte  in  8  stream byte
- in_ready  out  1  loader can take a byte; a byte transfers on in_valid && in_ready at the clk rising edge
- clear  in  1  synchronous abort/restart request
- RAM_WA  out  ADDR_W  program RAM write address
- RAM_WD  out  DATA_W  program RAM write data
- RAM_EN  out  1  program RAM write enable, one-cycle pulse per word
- PC_EN  out  1  CPU run enable
- busy  out  1  frame in progress (any state except IDLE, RUN, ERR)
- done  out  1  frame loaded and verified
- err  out  1  frame rejected

## Operation

- Frame format: header 0xA5, count N (1..WORDS), N words of 3 bytes each, checksum byte.
- Word bytes per word, in order:
  - b0: bits[1:0] → word[17:16]; bits[7:2] must be 0.
  - b1 → word[15:8].
  - b2 → word[7:0].
- Checksum = XOR of all 3N word bytes, seeded 0x00. The header and count bytes are excluded.
- FSM states: IDLE, COUNT, B0, B1, B2, CHK, RUN, ERR.
- Transitions:
  - IDLE: 0xA5 → COUNT; any other byte is discarded and the FSM stays in IDLE.
  - COUNT: N=0 or N>WORDS → ERR; otherwise latch N, clear the address counter and checksum, → B0.
  - B0: bits[7:2]≠0 → ERR; otherwise → B1.
  - B1: → B2.
  - B2: → B0 if words remain, else → CHK.
  - CHK: match → RUN; mismatch → ERR.
  - RUN, ERR: hold until clear.
- Every accepted word byte updates the running checksum.
- When b2 is accepted, the assembled word and the current address are registered. The address counter then increments from 0 to N-1.
- clear from any state → IDLE on the next edge:
  - RAM_EN, PC_EN, done and err drop.
  - A partially assembled word is discarded.
- clear has priority over every other event.
- RAM contents already written are not erased on ERR or clear.

## Timing

- Reset values: RAM_WA=0, RAM_WD=0, RAM_EN=0, PC_EN=0, done=0, err=0, busy=0, state IDLE, in_ready=1.
- in_ready:
  - 1 in IDLE, COUNT, B0, B1, B2 and CHK.
  - 0 in RUN and ERR.
  - 0 whenever clear=1; a byte presented in that cycle is not consumed.
- All outputs except in_ready are registered.
- RAM_EN is high for exactly the cycle after b2 acceptance, with RAM_WA/RAM_WD valid in that same cycle. RAM_WA/RAM_WD hold their last values otherwise.
- Back-to-back bytes are accepted at one per cycle with no stalls. The next word's b0 may be accepted during the RAM_EN cycle.
- The checksum may be accepted during the final RAM_EN cycle. PC_EN and done rise the cycle after checksum acceptance, so the last write always completes before PC_EN.
- err rises the cycle after the offending byte is accepted.
- in_valid gaps of any length are allowed in any receiving state; the state is held.
- Asynchronous rst_n mid-frame returns to the reset values immediately. A RAM_EN pulse in flight is cut.

## Test plan

- Reset with in_valid=1 and in_byte=0xA5, then release → all outputs at reset values and in_ready=1; the first accepted 0xA5 after release moves the FSM to COUNT.
- Stream A5 02 00 58 00 02 84 00 DE at one byte per cycle → two RAM_EN pulses, WA=0/WD=18'h05800 then WA=1/WD=18'h28400; PC_EN=1 and done=1 one cycle after DE is accepted; in_ready=0.
- Same frame with checksum DF → both RAM_EN pulses occur; err=1 and PC_EN=0.
- Count byte 0x0A, and separately a b0 of 0x04 → err=1 the next cycle, no RAM_EN pulse, in_ready=0.
- Prefix 12 FF before a valid frame, with random in_valid gaps → the prefix is ignored and the result matches the two-word load exactly.
- clear asserted after b1 of word 0 → IDLE next cycle and no RAM_EN; the next frame A5 01 00 11 22 33 → WA=0, WD=18'h01122, done=1. Then clear in RUN → PC_EN and done drop the next cycle.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream (0xA5, count, 3-byte words,
// XOR checksum), writes the assembled 18-bit words into the CPU program RAM
// and releases the CPU through PC_EN once the frame checksum is verified.
module program_loader #(
  parameter int WORDS  = 9,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  input  logic              clear,
  output logic [ADDR_W-1:0] RAM_WA,
  output logic [DATA_W-1:0] RAM_WD,
  output logic              RAM_EN,
  output logic              PC_EN,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, COUNT, B0, B1, B2, CHK, RUN, ERR
  } state_t;

  localparam logic [7:0] HEADER = 8'hA5;

  state_t            state;
  logic [ADDR_W-1:0] word_count;
  logic [ADDR_W-1:0] addr_cnt;
  logic [7:0]        csum;
  logic [1:0]        hi_bits;
  logic [7:0]        mid_byte;
  logic              accept;

  // Bytes are refused while parked in RUN/ERR and in any cycle clear is high,
  // so a byte offered alongside clear is never consumed.
  assign in_ready = !clear && (state != RUN) && (state != ERR);
  assign accept   = in_valid && in_ready;

  // Frame parser FSM with registered RAM load port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_count <= '0;
      addr_cnt   <= '0;
      csum       <= '0;
      hi_bits    <= '0;
      mid_byte   <= '0;
      RAM_WA     <= '0;
      RAM_WD     <= '0;
      RAM_EN     <= 1'b0;
      PC_EN      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      RAM_EN <= 1'b0;
      if (clear) begin
        state <= IDLE;
        PC_EN <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b0;
        err   <= 1'b0;
      end else if (accept) begin
        case (state)
          IDLE: begin
            if (in_byte == HEADER) begin
              state <= COUNT;
              busy  <= 1'b1;
            end
          end
          COUNT: begin
            if (in_byte == 8'd0 || int'(in_byte) > WORDS) begin
              state <= ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              word_count <= in_byte[ADDR_W-1:0];
              addr_cnt   <= '0;
              csum       <= '0;
              state      <= B0;
            end
          end
          B0: begin
            if (in_byte[7:2] != 6'd0) begin
              state <= ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              hi_bits <= in_byte[1:0];
              csum    <= csum ^ in_byte;
              state   <= B1;
            end
          end
          B1: begin
            mid_byte <= in_byte;
            csum     <= csum ^ in_byte;
            state    <= B2;
          end
          B2: begin
            RAM_WA   <= addr_cnt;
            RAM_WD   <= {hi_bits, mid_byte, in_byte};
            RAM_EN   <= 1'b1;
            csum     <= csum ^ in_byte;
            addr_cnt <= addr_cnt + ADDR_W'(1);
            if (addr_cnt == word_count - ADDR_W'(1)) state <= CHK;
            else                                     state <= B0;
          end
          CHK: begin
            busy <= 1'b0;
            if (in_byte == csum) begin
              state <= RUN;
              PC_EN <= 1'b1;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frames for program_loader with a write
// scoreboard; expected RAM writes are queued when a frame is built and
// popped whenever the loader pulses RAM_EN.
module tb_program_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        clear;
  logic [3:0]  ram_wa;
  logic [17:0] ram_wd;
  logic        ram_en;
  logic        pc_en;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [3:0]  wa;
    logic [17:0] wd;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] tx_q[$];
  int         checks   = 0;
  int         failures = 0;

  program_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_byte  (in_byte),
    .in_ready (in_ready),
    .clear    (clear),
    .RAM_WA   (ram_wa),
    .RAM_WD   (ram_wd),
    .RAM_EN   (ram_en),
    .PC_EN    (pc_en),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic expect_write(input logic [3:0] wa, input logic [17:0] wd);
    wr_t w;
    w.wa = wa;
    w.wd = wd;
    exp_q.push_back(w);
  endtask

  // Scoreboard: every RAM_EN pulse must match the oldest queued write.
  always @(negedge clk) begin
    if (rst_n && ram_en) begin
      check_output("ram_pc_exclusive", {31'd0, pc_en}, 32'd0);
      if (exp_q.size() == 0) begin
        check_output("unexpected_ram_en", {31'd0, ram_en}, 32'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check_output("ram_wa", {28'd0, ram_wa}, {28'd0, w.wa});
        check_output("ram_wd", {14'd0, ram_wd}, {14'd0, w.wd});
      end
    end
  end

  // Offers one byte after an optional idle gap and holds it until taken.
  task automatic apply_stimulus(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    for (int w = 0; w < 20 && !in_ready; w++) @(negedge clk);
    check_output("ready_for_byte", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_all(input int max_gap);
    while (tx_q.size() > 0) begin
      apply_stimulus(tx_q.pop_front(),
                     (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  // One-cycle clear with a header byte offered that must not be consumed.
  task automatic pulse_clear();
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'hA5;
    #1;
    check_output("ready_during_clear", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_output("idle_after_clear", {28'd0, busy, pc_en, done, err}, 32'd0);
  endtask

  task automatic queue_two_word(input logic [7:0] chk);
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h58, 8'h00, 8'h02, 8'h84, 8'h00};
    tx_q.push_back(chk);
    expect_write(4'd0, 18'h05800);
    expect_write(4'd1, 18'h28400);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] b0, b1, b2, x;

    rst_n    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b1;
    in_byte  = 8'hA5;

    // Reset held with a header offered: everything at reset values.
    repeat (3) @(negedge clk);
    check_output("reset_ram_wa", {28'd0, ram_wa}, 32'd0);
    check_output("reset_ram_wd", {14'd0, ram_wd}, 32'd0);
    check_output("reset_flags", {27'd0, ram_en, pc_en, busy, done, err}, 32'd0);
    check_output("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_output("header_to_count_busy", {31'd0, busy}, 32'd1);
    pulse_clear();

    // Valid two-word frame, back to back.
    queue_two_word(8'hDE);
    send_all(0);
    @(negedge clk);
    check_output("good_pc_en", {31'd0, pc_en}, 32'd1);
    check_output("good_done", {31'd0, done}, 32'd1);
    check_output("good_err_busy", {30'd0, err, busy}, 32'd0);
    check_output("good_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("good_writes_done", exp_q.size(), 32'd0);
    pulse_clear();

    // Bad checksum: writes still happen, then err.
    queue_two_word(8'hDF);
    send_all(0);
    @(negedge clk);
    check_output("badchk_err", {31'd0, err}, 32'd1);
    check_output("badchk_pc_done", {30'd0, pc_en, done}, 32'd0);
    check_output("badchk_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("badchk_writes_done", exp_q.size(), 32'd0);
    pulse_clear();

    // Count of 10 exceeds RAM depth.
    tx_q = '{8'hA5, 8'h0A};
    send_all(0);
    @(negedge clk);
    check_output("count10_err", {31'd0, err}, 32'd1);
    check_output("count10_in_ready", {31'd0, in_ready}, 32'd0);
    pulse_clear();

    // Count of zero.
    tx_q = '{8'hA5, 8'h00};
    send_all(0);
    @(negedge clk);
    check_output("count0_err", {31'd0, err}, 32'd1);
    pulse_clear();

    // b0 with a reserved bit set.
    tx_q = '{8'hA5, 8'h01, 8'h04};
    send_all(0);
    @(negedge clk);
    check_output("b0_err", {31'd0, err}, 32'd1);
    check_output("b0_in_ready", {31'd0, in_ready}, 32'd0);
    pulse_clear();

    // Junk prefix plus random valid gaps before the two-word frame.
    tx_q = '{8'h12, 8'hFF};
    send_all(3);
    queue_two_word(8'hDE);
    send_all(3);
    @(negedge clk);
    check_output("gap_done_pc", {30'd0, done, pc_en}, 32'd3);
    check_output("gap_err", {31'd0, err}, 32'd0);
    check_output("gap_writes_done", exp_q.size(), 32'd0);
    pulse_clear();

    // Full nine-word frame, checksum computed by the bench.
    tx_q = '{8'hA5, 8'h09};
    x = 8'h00;
    for (int i = 0; i < 9; i++) begin
      b0 = 8'($urandom_range(0, 3));
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      x  = x ^ b0 ^ b1 ^ b2;
      tx_q.push_back(b0);
      tx_q.push_back(b1);
      tx_q.push_back(b2);
      expect_write(4'(i), {b0[1:0], b1, b2});
    end
    tx_q.push_back(x);
    send_all(1);
    @(negedge clk);
    check_output("nine_done", {31'd0, done}, 32'd1);
    check_output("nine_writes_done", exp_q.size(), 32'd0);
    pulse_clear();

    // Abort mid-word: no write may appear.
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11};
    send_all(0);
    pulse_clear();
    repeat (2) @(negedge clk);
    check_output("abort_no_write_pending", exp_q.size(), 32'd0);

    // Fresh single-word frame after the abort.
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
    expect_write(4'd0, 18'h01122);
    send_all(0);
    @(negedge clk);
    check_output("single_done", {31'd0, done}, 32'd1);
    check_output("single_writes_done", exp_q.size(), 32'd0);

    // Clear in RUN drops PC_EN/done; RAM port holds its last values.
    pulse_clear();
    check_output("hold_ram_wa", {28'd0, ram_wa}, 32'd0);
    check_output("hold_ram_wd", {14'd0, ram_wd}, 32'h01122);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
